// File: rtl/cpu_pkg.sv
// Shared CPU constants: PC width, reset vector, sequential increment and the
// PC word type. The PC register and the next-PC logic both import this.
package cpu_pkg;

  localparam int PC_W = 16;

  typedef logic [PC_W-1:0] pc_t;

  localparam pc_t RESET_VECTOR = 16'h0000;
  localparam pc_t PC_INC       = 16'h0001;

  // Sequential successor of a PC; the carry out of the top bit is dropped.
  function automatic pc_t pc_step(input pc_t pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/pc_next_unit_ras_stack.sv
// ras_stack: circular return-address LIFO.
// push writes above the top (overwriting the oldest entry when full),
// pop drops the top, replace rewrites the top in place. The controls are
// expected to be mutually exclusive; push wins if they are not.
import cpu_pkg::*;

module ras_stack #(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     replace,
  input  pc_t                      push_data,
  output pc_t                      top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  pc_t              entries [DEPTH];
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W-1:0] ptr_up;
  logic [PTR_W-1:0] ptr_down;

  // DEPTH is a power of two, so pointer arithmetic wraps on its own and a
  // push into a full stack lands on the oldest entry.
  assign ptr_up   = top_ptr + PTR_W'(1);
  assign ptr_down = top_ptr - PTR_W'(1);

  assign top   = entries[top_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // Entry storage: contents are don't-care after reset, so no reset here.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (push)
        entries[ptr_up] <= push_data;
      else if (replace)
        entries[top_ptr] <= push_data;
    end
  end

  // Top pointer and occupancy count; count saturates at DEPTH on overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      top_ptr <= '0;
      count   <= '0;
    end else if (push) begin
      top_ptr <= ptr_up;
      if (!full)
        count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      top_ptr <= ptr_down;
      count   <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit: next-PC selection for the PC register.
// Priority: reset > stall > ret > call > jump > branch_taken > increment.
// Return addresses live in an internal ras_stack.
// Optional build macro PC_NEXT_RAS_ERR_EN adds the sticky ras_err output,
// set the cycle after a non-stalled RAS overflow push or underflow ret.
import cpu_pkg::*;

module pc_next_unit #(
  parameter int RAS_DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  pc_t                        pc_current,
  input  logic                       stall,
  input  logic                       branch_taken,
  input  pc_t                        branch_target,
  input  logic                       jump,
  input  logic                       call,
  input  pc_t                        jump_target,
  input  logic                       ret,
  output pc_t                        pc_next,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_empty,
  output logic                       ras_full
`ifdef PC_NEXT_RAS_ERR_EN
  ,output logic                      ras_err
`endif
);

  pc_t  pc_seq;
  pc_t  ras_top;
  logic active;
  logic ret_hit;
  logic do_push;
  logic do_pop;
  logic do_replace;

  assign pc_seq = pc_step(pc_current);
  assign active = !reset && !stall;

  // A ret only counts when there is something to return to; call+ret on a
  // non-empty stack rewrites the top, on an empty stack it is a plain call.
  assign ret_hit    = active && ret && !ras_empty;
  assign do_replace = ret_hit && call;
  assign do_pop     = ret_hit && !call;
  assign do_push    = active && call && !ret_hit;

  ras_stack #(
    .DEPTH     (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (do_push),
    .pop       (do_pop),
    .replace   (do_replace),
    .push_data (pc_seq),
    .top       (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  // Zero-latency priority mux feeding the PC register.
  always_comb begin
    pc_next = pc_seq;
    if (reset)
      pc_next = RESET_VECTOR;
    else if (stall)
      pc_next = pc_current;
    else if (ret_hit)
      pc_next = ras_top;
    else if (ret && !call)
      pc_next = pc_seq;
    else if (call || jump)
      pc_next = jump_target;
    else if (branch_taken)
      pc_next = branch_target;
  end

`ifdef PC_NEXT_RAS_ERR_EN
  logic overflow;
  logic underflow;

  assign overflow  = do_push && ras_full;
  assign underflow = active && ret && !call && ras_empty;

  // Sticky error flag; only reset clears it.
  always_ff @(posedge clock) begin
    if (reset)
      ras_err <= 1'b0;
    else if (overflow || underflow)
      ras_err <= 1'b1;
  end
`endif

endmodule
